axi4_burst_slave_ram: RTL and testbench
=======================================

# axi4_burst_slave_ram

AXI4 burst-capable slave memory that sits directly downstream of the JTAG-driven AXI master and terminates its read and write bursts. It provides a single-port word-addressed RAM window with FIXED, INCR and WRAP addressing, byte strobes and OKAY/SLVERR/DECERR responses. Its purposes are closed-loop bring-up of the host-to-fabric JTAG path and scratch storage in the FPGA design. One transaction is in flight at a time.

## Interface
- ID_WIDTH, 1, width of all ID fields
- AXI_DATA_WIDTH, 32, data width; 32 or 64 only
- AXI_ADDR_WIDTH, 32, address width; 32 or 64
- MEM_WORDS_LOG2, 10, log2 of RAM depth in data words
- aclk  in  1  single clock for all logic
- aclk_reset  in  1  reset; synchronous, active-high
- axi4s_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/AXI_ADDR_WIDTH/8/3/2  write address fields
- axi4s_awvalid  in  1; axi4s_awready  out  1  write address handshake
- axi4s_wdata/wstrb/wlast  in  AXI_DATA_WIDTH/(AXI_DATA_WIDTH/8)/1  write data fields
- axi4s_wvalid  in  1; axi4s_wready  out  1  write data handshake
- axi4s_bid/bresp  out  ID_WIDTH/2  write response fields
- axi4s_bvalid  out  1; axi4s_bready  in  1  write response handshake
- axi4s_arid/araddr/arlen/arsize/arburst  in  as AW  read address fields
- axi4s_arvalid  in  1; axi4s_arready  out  1  read address handshake
- axi4s_rid/rdata/rresp/rlast  out  ID_WIDTH/AXI_DATA_WIDTH/2/1  read data fields
- axi4s_rvalid  out  1; axi4s_rready  in  1  read data handshake
- prot/cache/lock/qos are not ports; the master ties them constant.

## Operation
- FSM states: IDLE, WDATA, WRESP, RPRIME, RDATA.
- IDLE arbitration, round-robin on simultaneous awvalid/arvalid:
  - after reset, write wins.
  - afterwards, the channel not granted last wins.
- Word index = addr[MEM_WORDS_LOG2+B-1:B], where B = log2(AXI_DATA_WIDTH/8). Low B address bits are ignored.
- Error classification, evaluated at AW/AR acceptance:
  - DECERR (2'b11): any address bit above the window is set.
  - SLVERR (2'b10): size ≠ B; burst = 2'b11; WRAP with len ∉ {1,3,7,15}.
  - Otherwise OKAY.
- Per-beat address update:
  - FIXED: unchanged.
  - INCR: word index +1, wraps modulo RAM depth.
  - WRAP: low log2(len+1) index bits increment modulo len+1; upper bits frozen.
- Write burst (WDATA):
  - Exactly awlen+1 beats are accepted.
  - Each OKAY beat writes RAM bytes gated by wstrb.
  - Error bursts are drained with no RAM writes.
  - If wlast is missing on the final beat or present on an earlier beat, bresp = SLVERR, unless already DECERR. Beats are still written.
- WRESP: bvalid held with stored bid/bresp until bready, then IDLE.
- Read burst: RPRIME issues the first RAM read; RDATA streams arlen+1 beats.
  - rlast is asserted on the final beat.
  - Error bursts return rdata = 0 and the error rresp on every beat.

## Timing
- Reset values: all ready/valid outputs 0; bresp, rresp, rdata, rlast, bid, rid 0; FSM in IDLE; arbiter favours write. RAM contents are not cleared.
- awready/arready: single-cycle pulse in IDLE, in the cycle the request is granted. Same cycle as acceptance: fields latched; error classified.
- wready is high throughout WDATA; one beat per cycle. The RAM write occurs on the handshake edge.
- bvalid asserts the cycle after the final W handshake.
- First rvalid asserts 2 cycles after the AR handshake (1-cycle RAM latency).
- With rready held high, one beat per cycle with no bubbles. The RAM read enable equals !rvalid || rready, so rdata is held stable while stalled.
- Return to IDLE: cycle after the final R or B handshake. The next grant is one cycle later, so a burst costs at least 1 dead cycle.
- aclk_reset mid-burst: the transaction is aborted with no response. Outputs take reset values on the next edge.
- awlen = 255 with INCR from the top index: the index wraps to 0 and the response is OKAY.

## Configuration
- AXI4S_RAM_WRAP_EN defined: WRAP addressing as above.
- Macro undefined: every WRAP burst is classified SLVERR and addressing logic is excluded.
  - Writes: beats drained, RAM unchanged.
  - Reads: zeros returned.

## Structure
- Package axi4s_ram_pkg holds:
  - resp constants OKAY/SLVERR/DECERR;
  - burst-type enum FIXED/INCR/WRAP;
  - FSM state enum;
  - next-address function (index, burst, len) → index.
- Sub-module axi4s_ram_sp: single-port RAM with byte-enable write and registered read, depth 2**MEM_WORDS_LOG2.

## Test plan
- INCR write, addr 0x40, awlen 3, data 0x11..0x44, wstrb all ones → bresp OKAY. Then read the same burst → beats 0x11,0x22,0x33,0x44, rlast on beat 4, first rvalid 2 cycles after arready.
- WRAP read, addr 0x38, arlen 3 (32-bit) → word order 14,15,12,13. With the macro undefined → rresp SLVERR ×4, rdata 0.
- Write to addr 1<<(MEM_WORDS_LOG2+2), awlen 1 → 2 beats accepted, bresp DECERR, RAM unchanged on readback.
- awvalid and arvalid asserted together three times → grants W, R, W.
- Read awlen 7 with rready toggling 1010… → rdata stable during stalls, 8 beats in order, no drops or duplicates.
- Assert aclk_reset during beat 2 of an 8-beat write → all outputs 0 next cycle. A subsequent write is accepted normally and returns bresp OKAY.

Source files
------------

// File: rtl/axi4s_ram_pkg.sv
// Shared definitions for the AXI4 burst slave RAM.
//   - AXI response codes
//   - burst-type and FSM state enums
//   - next_index(): per-beat word-index update for FIXED/INCR/WRAP
// Optional feature macro: AXI4S_RAM_WRAP_EN (WRAP addressing support).
package axi4s_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WRESP,
    ST_RPRIME,
    ST_RDATA
  } state_e;

  // Index is carried at 32 bits; the caller truncates to the RAM depth,
  // which gives INCR its modulo-depth wrap for free.
  function automatic logic [31:0] next_index(input logic [31:0] index,
                                             input logic [1:0]  burst,
                                             input logic [7:0]  len);
    logic [31:0] result;
`ifdef AXI4S_RAM_WRAP_EN
    logic [31:0] mask;
    // WRAP lengths are 2^n-1, so len itself is the mask of the wrapping bits.
    mask = {24'd0, len};
`else
    logic unused_len;
    unused_len = ^len;
`endif
    result = index;
    if (burst == BURST_INCR) begin
      result = index + 32'd1;
    end
`ifdef AXI4S_RAM_WRAP_EN
    else if (burst == BURST_WRAP) begin
      result = (index & ~mask) | ((index + 32'd1) & mask);
    end
`endif
    return result;
  endfunction

endpackage

// File: rtl/axi4s_ram_sp.sv
// Single-port RAM, byte-enable write, registered read (1-cycle latency).
// Ports:
//   clk   : clock
//   en    : port enable; with we=0 performs a read into rdata
//   we    : write enable (byte lanes gated by be)
//   addr  : word address, depth 2**ADDR_BITS
//   wdata : write data
//   be    : byte enables
//   rdata : registered read data, held while en is low
module axi4s_ram_sp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi4_burst_slave_ram.sv
// AXI4 burst slave memory: one transaction at a time, FIXED/INCR/WRAP bursts,
// byte strobes, OKAY/SLVERR/DECERR responses.
// Ports:
//   aclk, aclk_reset        : clock, synchronous active-high reset
//   axi4s_aw*  / awready    : write address channel
//   axi4s_w*   / wready     : write data channel
//   axi4s_b*   / bready     : write response channel
//   axi4s_ar*  / arready    : read address channel
//   axi4s_r*   / rready     : read data channel
// Optional feature macro: AXI4S_RAM_WRAP_EN. Without it every WRAP burst is
// answered SLVERR (writes drained, reads return zeros).
module axi4_burst_slave_ram
  import axi4s_ram_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 10
) (
  input  logic                        aclk,
  input  logic                        aclk_reset,
  input  logic [ID_WIDTH-1:0]         axi4s_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi4s_awaddr,
  input  logic [7:0]                  axi4s_awlen,
  input  logic [2:0]                  axi4s_awsize,
  input  logic [1:0]                  axi4s_awburst,
  input  logic                        axi4s_awvalid,
  output logic                        axi4s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi4s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi4s_wstrb,
  input  logic                        axi4s_wlast,
  input  logic                        axi4s_wvalid,
  output logic                        axi4s_wready,
  output logic [ID_WIDTH-1:0]         axi4s_bid,
  output logic [1:0]                  axi4s_bresp,
  output logic                        axi4s_bvalid,
  input  logic                        axi4s_bready,
  input  logic [ID_WIDTH-1:0]         axi4s_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi4s_araddr,
  input  logic [7:0]                  axi4s_arlen,
  input  logic [2:0]                  axi4s_arsize,
  input  logic [1:0]                  axi4s_arburst,
  input  logic                        axi4s_arvalid,
  output logic                        axi4s_arready,
  output logic [ID_WIDTH-1:0]         axi4s_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axi4s_rdata,
  output logic [1:0]                  axi4s_rresp,
  output logic                        axi4s_rlast,
  output logic                        axi4s_rvalid,
  input  logic                        axi4s_rready
);

  localparam int unsigned BYTE_LSB = $clog2(AXI_DATA_WIDTH/8);
  localparam int unsigned IDXW     = MEM_WORDS_LOG2;

  function automatic logic [1:0] classify(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                          input logic [2:0] size,
                                          input logic [1:0] burst,
                                          input logic [7:0] len);
    logic [1:0] resp;
`ifndef AXI4S_RAM_WRAP_EN
    logic unused_len;
    unused_len = ^len;
`endif
    resp = RESP_OKAY;
    if ((addr >> (MEM_WORDS_LOG2 + BYTE_LSB)) != '0) begin
      resp = RESP_DECERR;
    end else if (size != 3'(BYTE_LSB) || burst == 2'b11) begin
      resp = RESP_SLVERR;
    end else if (burst == BURST_WRAP) begin
`ifdef AXI4S_RAM_WRAP_EN
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) resp = RESP_SLVERR;
`else
      resp = RESP_SLVERR;
`endif
    end
    return resp;
  endfunction

  state_e                state, state_next;
  logic                  aw_grant, ar_grant;
  logic                  w_hs, r_hs, ram_en, ram_we;
  logic                  prefer_read;
  logic [ID_WIDTH-1:0]   id_q;
  logic [IDXW-1:0]       idx, next_idx;
  logic [1:0]            burst_q;
  logic [7:0]            len_q, left;
  logic [1:0]            resp_q;
  logic                  txn_ok;
  logic [1:0]            aw_class, ar_class;
  logic [AXI_DATA_WIDTH-1:0] ram_q;

  assign aw_class = classify(axi4s_awaddr, axi4s_awsize, axi4s_awburst, axi4s_awlen);
  assign ar_class = classify(axi4s_araddr, axi4s_arsize, axi4s_arburst, axi4s_arlen);
  assign next_idx = IDXW'(next_index(32'(idx), burst_q, len_q));

  // Round-robin: on a tie the channel not granted last wins; write after reset.
  assign aw_grant = (state == ST_IDLE) && !aclk_reset && axi4s_awvalid &&
                    (!axi4s_arvalid || !prefer_read);
  assign ar_grant = (state == ST_IDLE) && !aclk_reset && axi4s_arvalid && !aw_grant;
  assign axi4s_awready = aw_grant;
  assign axi4s_arready = ar_grant;

  always_ff @(posedge aclk) begin
    if (aclk_reset) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next   = state;
    axi4s_wready = 1'b0;
    axi4s_bvalid = 1'b0;
    axi4s_rvalid = 1'b0;
    w_hs         = 1'b0;
    r_hs         = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (aw_grant)      state_next = ST_WDATA;
        else if (ar_grant) state_next = ST_RPRIME;
      end
      ST_WDATA: begin
        axi4s_wready = 1'b1;
        if (axi4s_wvalid) begin
          w_hs   = 1'b1;
          ram_en = txn_ok;
          ram_we = txn_ok;
          if (left == 8'd0) state_next = ST_WRESP;
        end
      end
      ST_WRESP: begin
        axi4s_bvalid = 1'b1;
        if (axi4s_bready) state_next = ST_IDLE;
      end
      ST_RPRIME: begin
        ram_en     = 1'b1;
        state_next = ST_RDATA;
      end
      ST_RDATA: begin
        axi4s_rvalid = 1'b1;
        // Read enable follows !rvalid || rready: RAM output holds during a stall.
        ram_en = axi4s_rready;
        if (axi4s_rready) begin
          r_hs = 1'b1;
          if (left == 8'd0) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      prefer_read <= 1'b0;
      id_q        <= '0;
      idx         <= '0;
      burst_q     <= '0;
      len_q       <= '0;
      left        <= '0;
      resp_q      <= RESP_OKAY;
      txn_ok      <= 1'b0;
    end else begin
      if (aw_grant) begin
        id_q        <= axi4s_awid;
        idx         <= axi4s_awaddr[IDXW+BYTE_LSB-1:BYTE_LSB];
        burst_q     <= axi4s_awburst;
        len_q       <= axi4s_awlen;
        left        <= axi4s_awlen;
        resp_q      <= aw_class;
        txn_ok      <= (aw_class == RESP_OKAY);
        prefer_read <= 1'b1;
      end else if (ar_grant) begin
        id_q        <= axi4s_arid;
        idx         <= axi4s_araddr[IDXW+BYTE_LSB-1:BYTE_LSB];
        burst_q     <= axi4s_arburst;
        len_q       <= axi4s_arlen;
        left        <= axi4s_arlen;
        resp_q      <= ar_class;
        txn_ok      <= (ar_class == RESP_OKAY);
        prefer_read <= 1'b0;
      end
      if (w_hs) begin
        idx  <= next_idx;
        left <= left - 8'd1;
        // Beats keep writing; only the response records the wlast violation.
        if ((axi4s_wlast != (left == 8'd0)) && resp_q != RESP_DECERR)
          resp_q <= RESP_SLVERR;
      end
      // Index runs one beat ahead of the data presented on R.
      if (state == ST_RPRIME || r_hs) idx <= next_idx;
      if (r_hs) left <= left - 8'd1;
    end
  end

  axi4s_ram_sp #(
    .DATA_WIDTH(AXI_DATA_WIDTH),
    .ADDR_BITS (MEM_WORDS_LOG2)
  ) u_ram (
    .clk  (aclk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx),
    .wdata(axi4s_wdata),
    .be   (axi4s_wstrb),
    .rdata(ram_q)
  );

  assign axi4s_bid   = id_q;
  assign axi4s_rid   = id_q;
  assign axi4s_bresp = axi4s_bvalid ? resp_q : RESP_OKAY;
  assign axi4s_rresp = axi4s_rvalid ? resp_q : RESP_OKAY;
  assign axi4s_rlast = axi4s_rvalid && (left == 8'd0);
  assign axi4s_rdata = (axi4s_rvalid && resp_q == RESP_OKAY) ? ram_q : '0;

endmodule

// File: tb/tb_axi4_burst_slave_ram.sv
module tb_axi4_burst_slave_ram;

  logic        aclk, aclk_reset;
  logic [0:0]  axi4s_awid, axi4s_bid, axi4s_arid, axi4s_rid;
  logic [31:0] axi4s_awaddr, axi4s_araddr, axi4s_wdata, axi4s_rdata;
  logic [7:0]  axi4s_awlen, axi4s_arlen;
  logic [2:0]  axi4s_awsize, axi4s_arsize;
  logic [1:0]  axi4s_awburst, axi4s_arburst, axi4s_bresp, axi4s_rresp;
  logic [3:0]  axi4s_wstrb;
  logic        axi4s_awvalid, axi4s_awready, axi4s_wlast, axi4s_wvalid, axi4s_wready;
  logic        axi4s_bvalid, axi4s_bready, axi4s_arvalid, axi4s_arready;
  logic        axi4s_rlast, axi4s_rvalid, axi4s_rready;

  axi4_burst_slave_ram #(
    .ID_WIDTH(1), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .MEM_WORDS_LOG2(10)
  ) dut (
    .aclk(aclk), .aclk_reset(aclk_reset),
    .axi4s_awid(axi4s_awid), .axi4s_awaddr(axi4s_awaddr), .axi4s_awlen(axi4s_awlen),
    .axi4s_awsize(axi4s_awsize), .axi4s_awburst(axi4s_awburst),
    .axi4s_awvalid(axi4s_awvalid), .axi4s_awready(axi4s_awready),
    .axi4s_wdata(axi4s_wdata), .axi4s_wstrb(axi4s_wstrb), .axi4s_wlast(axi4s_wlast),
    .axi4s_wvalid(axi4s_wvalid), .axi4s_wready(axi4s_wready),
    .axi4s_bid(axi4s_bid), .axi4s_bresp(axi4s_bresp), .axi4s_bvalid(axi4s_bvalid),
    .axi4s_bready(axi4s_bready),
    .axi4s_arid(axi4s_arid), .axi4s_araddr(axi4s_araddr), .axi4s_arlen(axi4s_arlen),
    .axi4s_arsize(axi4s_arsize), .axi4s_arburst(axi4s_arburst),
    .axi4s_arvalid(axi4s_arvalid), .axi4s_arready(axi4s_arready),
    .axi4s_rid(axi4s_rid), .axi4s_rdata(axi4s_rdata), .axi4s_rresp(axi4s_rresp),
    .axi4s_rlast(axi4s_rlast), .axi4s_rvalid(axi4s_rvalid), .axi4s_rready(axi4s_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed { logic id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct packed { logic id; logic [1:0] resp; } bexp_t;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  rexp_t       rq[$];
  bexp_t       bq[$];
  rexp_t       rx;
  bexp_t       bx;
  int unsigned n_checks = 0, n_pass = 0;
  logic [31:0] wbuf [256];
  logic [3:0]  wstrb_cur = 4'hF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no response expected one within budget", name);
  endtask

  task automatic push_r(input logic id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    rexp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  // Monitor: pops expected B/R responses whenever the DUT presents one.
  always @(negedge aclk) begin
    if (!aclk_reset) begin
      if (axi4s_bvalid && axi4s_bready) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else begin
          bx = bq.pop_front();
          check("bresp", {axi4s_bid, axi4s_bresp}, bx);
        end
      end
      if (axi4s_rvalid) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else if (axi4s_rready) begin
          rx = rq.pop_front();
          check("rbeat", {axi4s_rid, axi4s_rdata, axi4s_rresp, axi4s_rlast}, rx);
        end else begin
          check("r_stall_hold", axi4s_rdata, rq[0].data);
        end
      end
    end
  end

  task automatic w_beat(input logic [31:0] d, input logic last, output bit ok);
    axi4s_wdata = d; axi4s_wstrb = wstrb_cur; axi4s_wlast = last; axi4s_wvalid = 1'b1;
    ok = 1'b0;
    for (int unsigned k = 0; k < 64; k++) begin
      @(negedge aclk);
      if (axi4s_wready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
  endtask

  task automatic aw_req(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                        input logic id, output bit ok);
    @(posedge aclk); #1;
    axi4s_awid = id; axi4s_awaddr = addr; axi4s_awlen = len;
    axi4s_awsize = 3'd2; axi4s_awburst = burst; axi4s_awvalid = 1'b1;
    ok = 1'b0;
    for (int unsigned k = 0; k < 64; k++) begin
      @(negedge aclk);
      if (axi4s_awready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    axi4s_awvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic id,
                             input logic [1:0] exp_resp, input bit early_last);
    bit ok;
    bexp_t e;
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    aw_req(addr, len, burst, id, ok);
    if (!ok) begin fail_now("aw_timeout"); return; end
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      w_beat(wbuf[i], early_last ? (i == 0) : (i == 32'(len)), ok);
      if (!ok) begin axi4s_wvalid = 1'b0; fail_now("w_timeout"); return; end
    end
    axi4s_wvalid = 1'b0; axi4s_wlast = 1'b0;
    for (int unsigned k = 0; k < 64; k++) begin
      if (bq.size() == 0) break;
      @(posedge aclk); #1;
    end
    if (bq.size() != 0) begin fail_now("b_timeout"); bq.delete(); end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic id, input bit toggle);
    bit ok;
    @(posedge aclk); #1;
    axi4s_arid = id; axi4s_araddr = addr; axi4s_arlen = len;
    axi4s_arsize = size; axi4s_arburst = burst; axi4s_arvalid = 1'b1; axi4s_rready = 1'b1;
    ok = 1'b0;
    for (int unsigned k = 0; k < 64; k++) begin
      @(negedge aclk);
      if (axi4s_arready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    axi4s_arvalid = 1'b0;
    if (!ok) begin fail_now("ar_timeout"); return; end
    @(negedge aclk); check("r_prime_gap", axi4s_rvalid, 1'b0);
    @(negedge aclk); check("r_first_lat", axi4s_rvalid, 1'b1);
    for (int unsigned k = 0; k < 600; k++) begin
      if (rq.size() == 0) break;
      @(posedge aclk); #1;
      if (toggle) axi4s_rready = ~axi4s_rready;
    end
    axi4s_rready = 1'b1;
    if (rq.size() != 0) begin fail_now("r_timeout"); rq.delete(); end
  endtask

  initial begin
    bit ok;
    logic [5:0] order;
    int unsigned ng;

    aclk_reset = 1'b1;
    axi4s_awid = '0; axi4s_awaddr = '0; axi4s_awlen = '0; axi4s_awsize = 3'd2;
    axi4s_awburst = INCR; axi4s_awvalid = 1'b0;
    axi4s_wdata = '0; axi4s_wstrb = '0; axi4s_wlast = 1'b0; axi4s_wvalid = 1'b0;
    axi4s_bready = 1'b1;
    axi4s_arid = '0; axi4s_araddr = '0; axi4s_arlen = '0; axi4s_arsize = 3'd2;
    axi4s_arburst = INCR; axi4s_arvalid = 1'b0; axi4s_rready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_outputs", {axi4s_awready, axi4s_arready, axi4s_wready, axi4s_bvalid,
          axi4s_rvalid, axi4s_bresp, axi4s_rresp, axi4s_rdata, axi4s_rlast,
          axi4s_bid, axi4s_rid}, '0);
    @(posedge aclk); #1 aclk_reset = 1'b0;

    // Simultaneous requests held high: write first after reset, then alternate.
    axi4s_awaddr = 32'h100; axi4s_awlen = 8'd0; axi4s_awburst = INCR; axi4s_awid = '0;
    axi4s_araddr = 32'h100; axi4s_arlen = 8'd0; axi4s_arburst = INCR; axi4s_arid = '0;
    axi4s_wdata = 32'hA5A5_0001; axi4s_wstrb = 4'hF; axi4s_wlast = 1'b1; axi4s_wvalid = 1'b1;
    bq.push_back('{id: 1'b0, resp: OKAY});
    bq.push_back('{id: 1'b0, resp: OKAY});
    push_r(1'b0, 32'hA5A5_0001, OKAY, 1'b1);
    @(posedge aclk); #1;
    axi4s_awvalid = 1'b1; axi4s_arvalid = 1'b1;
    order = '0; ng = 0;
    for (int unsigned k = 0; k < 100 && ng < 3; k++) begin
      @(negedge aclk);
      if (axi4s_awready)      begin order = {order[3:0], 2'd1}; ng++; end
      else if (axi4s_arready) begin order = {order[3:0], 2'd2}; ng++; end
    end
    @(posedge aclk); #1;
    axi4s_awvalid = 1'b0; axi4s_arvalid = 1'b0;
    check("grant_order", order, 6'b01_10_01);
    for (int unsigned k = 0; k < 64; k++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      @(posedge aclk); #1;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      fail_now("grant_drain"); bq.delete(); rq.delete();
    end
    axi4s_wvalid = 1'b0; axi4s_wlast = 1'b0;

    // INCR write then readback.
    for (int unsigned i = 0; i < 4; i++) wbuf[i] = 32'h11 * (i + 1);
    write_burst(32'h40, 8'd3, INCR, 1'b1, OKAY, 1'b0);
    for (int unsigned i = 0; i < 4; i++) push_r(1'b1, 32'h11 * (i + 1), OKAY, i == 3);
    read_burst(32'h40, 8'd3, INCR, 3'd2, 1'b1, 1'b0);

    // Partial byte strobes over word 0x40 (0x00000011).
    wstrb_cur = 4'b0101; wbuf[0] = 32'hFFFF_FFFF;
    write_burst(32'h40, 8'd0, INCR, 1'b0, OKAY, 1'b0);
    wstrb_cur = 4'hF;
    push_r(1'b0, 32'h00FF_00FF, OKAY, 1'b1);
    read_burst(32'h40, 8'd0, FIXED, 3'd2, 1'b0, 1'b0);

    // WRAP read starting at word 14 of the 12..15 block.
    for (int unsigned i = 0; i < 4; i++) wbuf[i] = 32'hD000_000C + i;
    write_burst(32'h30, 8'd3, INCR, 1'b0, OKAY, 1'b0);
`ifdef AXI4S_RAM_WRAP_EN
    push_r(1'b0, 32'hD000_000E, OKAY, 1'b0);
    push_r(1'b0, 32'hD000_000F, OKAY, 1'b0);
    push_r(1'b0, 32'hD000_000C, OKAY, 1'b0);
    push_r(1'b0, 32'hD000_000D, OKAY, 1'b1);
`else
    for (int unsigned i = 0; i < 4; i++) push_r(1'b0, 32'h0, SLVERR, i == 3);
`endif
    read_burst(32'h38, 8'd3, WRAP, 3'd2, 1'b0, 1'b0);
    // WRAP with an illegal length, and a bad size: SLVERR in any build.
    for (int unsigned i = 0; i < 3; i++) push_r(1'b0, 32'h0, SLVERR, i == 2);
    read_burst(32'h38, 8'd2, WRAP, 3'd2, 1'b0, 1'b0);
    push_r(1'b1, 32'h0, SLVERR, 1'b1);
    read_burst(32'h40, 8'd0, INCR, 3'd3, 1'b1, 1'b0);

    // DECERR write just above the window must leave word 0/1 untouched.
    wbuf[0] = 32'hAAAA_0000; wbuf[1] = 32'hAAAA_0001;
    write_burst(32'h0, 8'd1, INCR, 1'b0, OKAY, 1'b0);
    wbuf[0] = 32'hDEAD_0000; wbuf[1] = 32'hDEAD_0001;
    write_burst(32'h1000, 8'd1, INCR, 1'b1, DECERR, 1'b0);
    push_r(1'b0, 32'hAAAA_0000, OKAY, 1'b0);
    push_r(1'b0, 32'hAAAA_0001, OKAY, 1'b1);
    read_burst(32'h0, 8'd1, INCR, 3'd2, 1'b0, 1'b0);
    push_r(1'b1, 32'h0, DECERR, 1'b1);
    read_burst(32'h1000, 8'd0, INCR, 3'd2, 1'b1, 1'b0);

    // wlast on the wrong beat: SLVERR, data still written.
    wbuf[0] = 32'hBB00_0000; wbuf[1] = 32'hBB00_0001;
    write_burst(32'h80, 8'd1, INCR, 1'b0, SLVERR, 1'b1);
    push_r(1'b0, 32'hBB00_0000, OKAY, 1'b0);
    push_r(1'b0, 32'hBB00_0001, OKAY, 1'b1);
    read_burst(32'h80, 8'd1, INCR, 3'd2, 1'b0, 1'b0);

    // 8-beat read with rready toggling.
    for (int unsigned i = 0; i < 8; i++) wbuf[i] = 32'h5000_0000 + i;
    write_burst(32'h200, 8'd7, INCR, 1'b0, OKAY, 1'b0);
    for (int unsigned i = 0; i < 8; i++) push_r(1'b0, 32'h5000_0000 + i, OKAY, i == 7);
    read_burst(32'h200, 8'd7, INCR, 3'd2, 1'b0, 1'b1);

    // 256-beat INCR from the top word wraps the index to 0.
    for (int unsigned i = 0; i < 256; i++) wbuf[i] = 32'h7700_0000 + i;
    write_burst(32'hFFC, 8'd255, INCR, 1'b1, OKAY, 1'b0);
    for (int unsigned i = 0; i < 3; i++) push_r(1'b1, 32'h7700_0000 + i, OKAY, i == 2);
    read_burst(32'hFFC, 8'd2, INCR, 3'd2, 1'b1, 1'b0);

    // Reset during beat 2 of an 8-beat write aborts it silently.
    aw_req(32'h300, 8'd7, INCR, 1'b1, ok);
    if (!ok) fail_now("aw_timeout_rst");
    w_beat(32'h3300_0000, 1'b0, ok);
    w_beat(32'h3300_0001, 1'b0, ok);
    axi4s_wdata = 32'h3300_0002; axi4s_wvalid = 1'b1; aclk_reset = 1'b1;
    @(posedge aclk); #1;
    aclk_reset = 1'b0; axi4s_wvalid = 1'b0;
    @(negedge aclk);
    check("reset_midburst_outputs", {axi4s_awready, axi4s_arready, axi4s_wready,
          axi4s_bvalid, axi4s_rvalid, axi4s_bresp, axi4s_rresp, axi4s_rdata,
          axi4s_rlast, axi4s_bid, axi4s_rid}, '0);
    wbuf[0] = 32'h4400_0000; wbuf[1] = 32'h4400_0001;
    write_burst(32'h300, 8'd1, INCR, 1'b0, OKAY, 1'b0);
    push_r(1'b0, 32'h4400_0000, OKAY, 1'b0);
    push_r(1'b0, 32'h4400_0001, OKAY, 1'b1);
    read_burst(32'h300, 8'd1, INCR, 3'd2, 1'b0, 1'b0);

    repeat (4) @(posedge aclk);
    check("bq_drained", 64'(bq.size()), 64'd0);
    check("rq_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
